// File: rtl/ps2_keyb_matrix.sv
// PS/2 set-2 keyboard receiver that keeps a 40-key Spectrum matrix in registers and
// answers the ULA half-row selects combinationally on kbcolumns.
module ps2_keyb_matrix #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 14000
) (
    input  logic       clk14,
    input  logic       rst,
    input  logic       ps2clk,
    input  logic       ps2data,
    input  logic [7:0] kbrows,
    output logic [4:0] kbcolumns,
    output logic       scan_strobe,
    output logic [7:0] scancode,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    // Synchronisers and glitch filter
    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic          filt_q, filt_d;
    logic          filt_prev_q, filt_prev_d;
    logic [FW-1:0] fcnt_q, fcnt_d;

    // Receiver
    rx_state_e     state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    // Decoded byte handling and outputs
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic [39:0]   keys_q, keys_d;
    logic [7:0]    scancode_q, scancode_d;
    logic          strobe_q, strobe_d;
    logic          err_q, err_d;

    logic          fall;
    logic          data_s;
    logic          key_hit;
    logic [5:0]    key_idx;

    assign data_s = dat_sync_q[1];
    assign fall   = filt_prev_q & ~filt_q;

    // Set-2 code to matrix cell; cell index is row*5 + column
    always_comb begin
        key_hit = 1'b1;
        key_idx = 6'd0;
        case (shift_q)
            8'h16: key_idx = 6'd35;  // 1
            8'h1E: key_idx = 6'd36;  // 2
            8'h26: key_idx = 6'd37;  // 3
            8'h25: key_idx = 6'd38;  // 4
            8'h2E: key_idx = 6'd39;  // 5
            8'h15: key_idx = 6'd30;  // Q
            8'h1D: key_idx = 6'd31;  // W
            8'h24: key_idx = 6'd32;  // E
            8'h2D: key_idx = 6'd33;  // R
            8'h2C: key_idx = 6'd34;  // T
            8'h1C: key_idx = 6'd25;  // A
            8'h1B: key_idx = 6'd26;  // S
            8'h23: key_idx = 6'd27;  // D
            8'h2B: key_idx = 6'd28;  // F
            8'h34: key_idx = 6'd29;  // G
            8'h45: key_idx = 6'd20;  // 0
            8'h46: key_idx = 6'd21;  // 9
            8'h3E: key_idx = 6'd22;  // 8
            8'h3D: key_idx = 6'd23;  // 7
            8'h36: key_idx = 6'd24;  // 6
            8'h4D: key_idx = 6'd15;  // P
            8'h44: key_idx = 6'd16;  // O
            8'h43: key_idx = 6'd17;  // I
            8'h3C: key_idx = 6'd18;  // U
            8'h35: key_idx = 6'd19;  // Y
            8'h12: key_idx = 6'd10;  // caps shift (left shift)
            8'h1A: key_idx = 6'd11;  // Z
            8'h22: key_idx = 6'd12;  // X
            8'h21: key_idx = 6'd13;  // C
            8'h2A: key_idx = 6'd14;  // V
            8'h5A: key_idx = 6'd5;   // enter
            8'h4B: key_idx = 6'd6;   // L
            8'h42: key_idx = 6'd7;   // K
            8'h3B: key_idx = 6'd8;   // J
            8'h33: key_idx = 6'd9;   // H
            8'h29: key_idx = 6'd0;   // space
            8'h59: key_idx = 6'd1;   // symbol shift (right shift)
            8'h14: key_idx = 6'd1;   // symbol shift (left ctrl)
            8'h3A: key_idx = 6'd2;   // M
            8'h31: key_idx = 6'd3;   // N
            8'h32: key_idx = 6'd4;   // B
            default: key_hit = 1'b0;
        endcase
    end

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2clk};
        dat_sync_d  = {dat_sync_q[0], ps2data};
        filt_d      = filt_q;
        filt_prev_d = filt_q;
        fcnt_d      = '0;
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tcnt_d      = tcnt_q;
        brk_d       = brk_q;
        ext_d       = ext_q;
        keys_d      = keys_q;
        scancode_d  = scancode_q;
        strobe_d    = 1'b0;
        err_d       = 1'b0;

        // Filtered level flips only after FILTER_LEN consecutive differing samples
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end

        if (fall || state_q == StIdle) begin
            tcnt_d = '0;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
            tcnt_d  = '0;
            err_d   = 1'b1;
            state_d = StIdle;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end

        if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!data_s) begin
                        state_d  = StData;
                        bitcnt_d = 3'd0;
                    end
                end
                StData: begin
                    shift_d  = {data_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    par_d   = data_s;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (data_s && (^{shift_q, par_q})) begin
                        scancode_d = shift_q;
                        strobe_d   = 1'b1;
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            if (!ext_q) begin
                                if (key_hit) begin
                                    keys_d[key_idx] = ~brk_q;
                                end else if (shift_q == 8'h76 && !brk_q) begin
                                    keys_d = '0;
                                end
                            end
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk14 or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= StIdle;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'd0;
            par_q       <= 1'b0;
            tcnt_q      <= '0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            keys_q      <= '0;
            scancode_q  <= 8'd0;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tcnt_q      <= tcnt_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            keys_q      <= keys_d;
            scancode_q  <= scancode_d;
            strobe_q    <= strobe_d;
            err_q       <= err_d;
        end
    end

    // Wired-AND of every selected half-row, no clock in the path
    always_comb begin
        logic [4:0] cols;
        cols = 5'b11111;
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < 5; j++) begin
                if (!kbrows[r] && keys_q[r*5+j]) begin
                    cols[j] = 1'b0;
                end
            end
        end
        kbcolumns = cols;
    end

    assign scan_strobe = strobe_q;
    assign scancode    = scancode_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_ps2_keyb_matrix.sv
// Directed bench for ps2_keyb_matrix: PS/2 frames in, scoreboard of accepted scancodes,
// matrix state read back through kbrows/kbcolumns.
module tb_ps2_keyb_matrix;

    logic       clk14 = 1'b0;
    logic       rst = 1'b1;
    logic       ps2clk = 1'b1;
    logic       ps2data = 1'b1;
    logic [7:0] kbrows = 8'hFF;
    logic [4:0] kbcolumns;
    logic       scan_strobe;
    logic [7:0] scancode;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;
    logic [7:0] exp_q[$];

    localparam int HALF = 20;

    ps2_keyb_matrix dut (
        .clk14      (clk14),
        .rst        (rst),
        .ps2clk     (ps2clk),
        .ps2data    (ps2data),
        .kbrows     (kbrows),
        .kbcolumns  (kbcolumns),
        .scan_strobe(scan_strobe),
        .scancode   (scancode),
        .frame_err  (frame_err)
    );

    always #5 clk14 = ~clk14;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest pushed scancode
    always @(negedge clk14) begin
        if (!rst && frame_err) err_cnt++;
        if (!rst && scan_strobe) begin
            strobe_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL unexpected_strobe observed=%0h expected=none", scancode);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                assert (scancode === e) else begin
                    errors++;
                    $error("FAIL scancode observed=%0h expected=%0h", scancode, e);
                end
            end
        end
    end

    // Sends the first nbits bits of a frame; odd parity unless bad_par
    task automatic ps2_send(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2data = fr[i];
            repeat (HALF) @(posedge clk14);
            ps2clk = 1'b0;
            repeat (HALF) @(posedge clk14);
            ps2clk = 1'b1;
        end
        ps2data = 1'b1;
        repeat (60) @(posedge clk14);
    endtask

    task automatic send_ok(input logic [7:0] b);
        exp_q.push_back(b);
        ps2_send(b, 1'b0, 11);
        chk($sformatf("strobe_seen_%0h", b), exp_q.size(), 0);
    endtask

    task automatic cols(input string tag, input logic [7:0] rows, input logic [4:0] exp);
        @(negedge clk14);
        kbrows = rows;
        #1;
        chk(tag, kbcolumns, exp);
    endtask

    initial begin
        int s0;
        int e0;
        repeat (3) @(negedge clk14);
        rst = 1'b0;
        repeat (2) @(negedge clk14);
        chk("rst_cols", kbcolumns, 5'b11111);
        cols("rst_cols_all_rows", 8'h00, 5'b11111);
        chk("rst_scancode", scancode, 8'h00);
        chk("rst_strobe", scan_strobe, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);

        // Press and release A
        s0 = strobe_cnt;
        send_ok(8'h1C);
        chk("press_a_strobes", strobe_cnt - s0, 1);
        chk("press_a_code", scancode, 8'h1C);
        cols("press_a_row5", 8'b11011111, 5'b11110);
        cols("press_a_norow", 8'b11111111, 5'b11111);
        s0 = strobe_cnt;
        send_ok(8'hF0);
        send_ok(8'h1C);
        chk("release_a_strobes", strobe_cnt - s0, 2);
        chk("release_a_code", scancode, 8'h1C);
        cols("release_a_row5", 8'b11011111, 5'b11111);

        // Merged rows with CAPS SHIFT and Q held
        send_ok(8'h12);
        send_ok(8'h15);
        cols("merge_two_rows", 8'b10111011, 5'b11110);
        cols("merge_row2", 8'b11111011, 5'b11110);
        cols("merge_row7", 8'b01111111, 5'b11111);

        // Parity error
        s0 = strobe_cnt;
        e0 = err_cnt;
        ps2_send(8'h1C, 1'b1, 11);
        chk("parity_err_pulse", err_cnt - e0, 1);
        chk("parity_no_strobe", strobe_cnt - s0, 0);
        cols("parity_matrix", 8'b11011111, 5'b11111);
        send_ok(8'h1C);
        cols("parity_recover", 8'b11011111, 5'b11110);

        // Timeout on a partial frame
        e0 = err_cnt;
        ps2_send(8'h1C, 1'b0, 4);
        repeat (15000) @(posedge clk14);
        chk("timeout_err_pulse", err_cnt - e0, 1);
        send_ok(8'h16);
        cols("timeout_recover_key1", 8'b01111111, 5'b11110);

        // Extended code leaves ENTER alone
        send_ok(8'hE0);
        send_ok(8'h5A);
        cols("ext_enter", 8'b11111101, 5'b11111);

        // Reset mid-frame
        ps2_send(8'h29, 1'b0, 5);
        @(negedge clk14);
        rst = 1'b1;
        repeat (3) @(negedge clk14);
        rst = 1'b0;
        repeat (2) @(negedge clk14);
        cols("midrst_cols", 8'h00, 5'b11111);
        chk("midrst_scancode", scancode, 8'h00);
        send_ok(8'h29);
        cols("post_rst_space", 8'b11111110, 5'b11110);

        // Esc releases everything
        send_ok(8'h1C);
        cols("pre_esc", 8'h00, 5'b11110);
        send_ok(8'h76);
        cols("esc_release_all", 8'h00, 5'b11111);

        repeat (10) @(negedge clk14);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
